// File: rtl/noc_pkg.sv
// Shared types and helpers for the NoC injection port: flit layout, VC count, round-robin pick.
// Field widths are fixed here so every user of flit_t agrees on the layout.
package noc_pkg;

    localparam int VC_W = 1;
    localparam int X_W  = 2;
    localparam int Y_W  = 2;
    localparam int D_W  = 28;
    localparam int N_VC = 1 << VC_W;

    typedef struct packed {
        logic [VC_W-1:0] vc;
        logic [X_W-1:0]  x;
        logic [Y_W-1:0]  y;
        logic [D_W-1:0]  data;
    } flit_t;

    localparam int FLIT_W = $bits(flit_t);

    // First requester at or after ptr, wrapping; returns ptr when nothing requests.
    function automatic logic [VC_W-1:0] rr_next(input logic [VC_W-1:0] ptr,
                                                input logic [N_VC-1:0] req);
        logic [VC_W-1:0] idx;
        logic [VC_W-1:0] grant;
        logic            found;
        grant = ptr;
        found = 1'b0;
        for (int i = 0; i < N_VC; i++) begin
            idx = ptr + VC_W'(i);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/noc_vc_fifo.sv
// Synchronous FIFO for one virtual channel; head visible combinationally (zero-latency read).
// Latency: push visible at dout the cycle after the write edge. Push refused while full, pop ignored while empty.
module noc_vc_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    // Full comes from the registered count, so a pop never frees space for a push in the same cycle.
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/noc_inject_port.sv
// Client injection responder: buffers offered packets per VC, acks each with a one-cycle pulse, drains round-robin.
// Latency: accepted packet can appear on out_v the cycle after capture, alongside i_ack; out_rdy low holds out_* stable.
module noc_inject_port
    import noc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_v,
    input  logic [VC_W-1:0] i_vc,
    input  logic [X_W-1:0]  i_x,
    input  logic [Y_W-1:0]  i_y,
    input  logic [D_W-1:0]  i_data,
    output logic            i_ack,
    output logic            out_v,
    output logic [VC_W-1:0] out_vc,
    output logic [X_W-1:0]  out_x,
    output logic [Y_W-1:0]  out_y,
    output logic [D_W-1:0]  out_data,
    input  logic            out_rdy,
    output logic [N_VC-1:0] vc_full,
    output logic [31:0]     pkt_in_cnt,
    output logic [31:0]     pkt_out_cnt
);

    flit_t           in_flit;
    flit_t           head [N_VC];
    logic [N_VC-1:0] push;
    logic [N_VC-1:0] pop;
    logic [N_VC-1:0] empty;
    logic [N_VC-1:0] full;
    logic            ack_q;
    logic            accept;
    logic            fire;
    logic [VC_W-1:0] ptr;
    logic [VC_W-1:0] grant;

    // The client still shows the accepted packet during its ack cycle, so the ack itself blocks re-capture.
    assign accept = i_v && !ack_q && !full[i_vc];

    assign in_flit.vc   = i_vc;
    assign in_flit.x    = i_x;
    assign in_flit.y    = i_y;
    assign in_flit.data = i_data;

    assign grant    = rr_next(ptr, ~empty);
    assign out_v    = ~&empty;
    assign fire     = out_v && out_rdy;
    assign out_vc   = head[grant].vc;
    assign out_x    = head[grant].x;
    assign out_y    = head[grant].y;
    assign out_data = head[grant].data;

    for (genvar g = 0; g < N_VC; g++) begin : g_vc
        assign push[g] = accept && (i_vc == VC_W'(g));
        assign pop[g]  = fire && (grant == VC_W'(g));

        noc_vc_fifo #(
            .W     (FLIT_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .din   (in_flit),
            .pop   (pop[g]),
            .dout  (head[g]),
            .empty (empty[g]),
            .full  (full[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q       <= 1'b0;
            ptr         <= '0;
            pkt_in_cnt  <= '0;
            pkt_out_cnt <= '0;
        end else begin
            ack_q <= accept;
            if (accept) pkt_in_cnt <= pkt_in_cnt + 32'd1;
            if (fire) begin
                ptr         <= grant + VC_W'(1);
                pkt_out_cnt <= pkt_out_cnt + 32'd1;
            end
        end
    end

    assign i_ack   = ack_q;
    assign vc_full = full;

endmodule

// File: tb/tb_noc_inject_port.sv
// Directed bench for noc_inject_port: reset, back-to-back, full/backpressure, round-robin, full-with-pop, async reset.
module tb_noc_inject_port;
    import noc_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_v;
    logic [VC_W-1:0] i_vc;
    logic [X_W-1:0]  i_x;
    logic [Y_W-1:0]  i_y;
    logic [D_W-1:0]  i_data;
    logic            i_ack;
    logic            out_v;
    logic [VC_W-1:0] out_vc;
    logic [X_W-1:0]  out_x;
    logic [Y_W-1:0]  out_y;
    logic [D_W-1:0]  out_data;
    logic            out_rdy;
    logic [N_VC-1:0] vc_full;
    logic [31:0]     pkt_in_cnt;
    logic [31:0]     pkt_out_cnt;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    noc_inject_port #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_v         (i_v),
        .i_vc        (i_vc),
        .i_x         (i_x),
        .i_y         (i_y),
        .i_data      (i_data),
        .i_ack       (i_ack),
        .out_v       (out_v),
        .out_vc      (out_vc),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_data    (out_data),
        .out_rdy     (out_rdy),
        .vc_full     (vc_full),
        .pkt_in_cnt  (pkt_in_cnt),
        .pkt_out_cnt (pkt_out_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_pkt(input logic [VC_W-1:0] vc, input logic [D_W-1:0] d);
        logic got;
        got    = 1'b0;
        i_vc   = vc;
        i_data = d;
        i_v    = 1'b1;
        for (int n = 0; n < 10 && !got; n++) begin
            step();
            got = i_ack;
        end
        i_v = 1'b0;
        chk("send_ack", {31'b0, got}, 32'd1);
    endtask

    // Six packets on VC0 with the client holding i_v; acks must land on every other cycle.
    task automatic b2b(input logic [D_W-1:0] base, input logic [31:0] in0, input logic [31:0] out0);
        int k;
        int outk;
        k       = 0;
        outk    = 0;
        i_vc    = '0;
        i_data  = base;
        i_v     = 1'b1;
        out_rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            chk("b2b_ack", {31'b0, i_ack}, (c % 2 == 0) ? 32'd1 : 32'd0);
            if (out_v) begin
                chk("b2b_data", {4'b0, out_data}, {4'b0, D_W'(base + D_W'(outk))});
                outk++;
            end
            if (i_ack) begin
                k++;
                if (k == 6) i_v = 1'b0;
                else        i_data = base + D_W'(k);
            end
        end
        step();
        chk("b2b_out_seen", 32'(outk), 32'd6);
        chk("b2b_in_cnt", pkt_in_cnt, in0 + 32'd6);
        chk("b2b_out_cnt", pkt_out_cnt, out0 + 32'd6);
    endtask

    logic [D_W-1:0] rr_exp [4];

    initial begin
        rst     = 1'b0;
        i_v     = 1'b1;
        i_vc    = '0;
        i_x     = 2'd1;
        i_y     = 2'd2;
        i_data  = 28'h0000ABC;
        out_rdy = 1'b0;

        // Reset held with a packet offered
        repeat (3) step();
        chk("rst_ack", {31'b0, i_ack}, 32'd0);
        chk("rst_out_v", {31'b0, out_v}, 32'd0);
        chk("rst_vc_full", {30'b0, vc_full}, 32'd0);
        chk("rst_in_cnt", pkt_in_cnt, 32'd0);
        chk("rst_out_cnt", pkt_out_cnt, 32'd0);
        rst = 1'b1;
        step();
        chk("first_ack", {31'b0, i_ack}, 32'd1);
        chk("first_out_v", {31'b0, out_v}, 32'd1);
        chk("first_data", {4'b0, out_data}, 32'h0000ABC);
        chk("first_xy", {28'b0, out_x, out_y}, 32'h6);
        chk("first_in_cnt", pkt_in_cnt, 32'd1);
        i_v = 1'b0;
        step();
        chk("first_ack_drop", {31'b0, i_ack}, 32'd0);
        out_rdy = 1'b1;
        step();
        chk("first_drained", {31'b0, out_v}, 32'd0);
        chk("first_out_cnt", pkt_out_cnt, 32'd1);

        b2b(28'h0100000, 32'd1, 32'd1);

        // Backpressure: five packets into VC1 with the router stalled
        begin
            int acks;
            int k;
            acks    = 0;
            k       = 0;
            out_rdy = 1'b0;
            i_vc    = 1'b1;
            i_data  = 28'h0E00000;
            i_v     = 1'b1;
            for (int c = 0; c < 12; c++) begin
                step();
                if (i_ack) begin
                    acks++;
                    k++;
                    i_data = 28'h0E00000 + D_W'(k);
                end
            end
            chk("bp_acks", 32'(acks), 32'd4);
            chk("bp_vc_full", {30'b0, vc_full}, 32'h2);
            chk("bp_head", {4'b0, out_data}, 32'h0E00000);
            out_rdy = 1'b1;
            step();
            out_rdy = 1'b0;
            chk("bp_pop_noack", {31'b0, i_ack}, 32'd0);
            chk("bp_unfull", {30'b0, vc_full}, 32'd0);
            chk("bp_next_head", {4'b0, out_data}, 32'h0E00001);
            step();
            chk("bp_5th_ack", {31'b0, i_ack}, 32'd1);
            i_v = 1'b0;
            step();
            chk("bp_refull", {30'b0, vc_full}, 32'h2);
            out_rdy = 1'b1;
            for (int j = 0; j < 4; j++) begin
                chk("bp_drain_data", {4'b0, out_data}, 32'h0E00001 + 32'(j));
                chk("bp_drain_vc", {31'b0, out_vc}, 32'd1);
                step();
            end
            chk("bp_empty", {31'b0, out_v}, 32'd0);
            chk("bp_in_cnt", pkt_in_cnt, 32'd12);
            chk("bp_out_cnt", pkt_out_cnt, 32'd12);
        end

        // Round robin with stalls: pointer is back at VC0 after the last VC1 pop
        out_rdy = 1'b0;
        send_pkt(1'b0, 28'h00000A0);
        send_pkt(1'b1, 28'h00000B0);
        send_pkt(1'b0, 28'h00000A1);
        send_pkt(1'b1, 28'h00000B1);
        rr_exp[0] = 28'h00000A0;
        rr_exp[1] = 28'h00000B0;
        rr_exp[2] = 28'h00000A1;
        rr_exp[3] = 28'h00000B1;
        for (int j = 0; j < 4; j++) begin
            chk("rr_order", {4'b0, out_data}, {4'b0, rr_exp[j]});
            out_rdy = 1'b0;
            step();
            chk("rr_stall_v", {31'b0, out_v}, 32'd1);
            chk("rr_stall_data", {4'b0, out_data}, {4'b0, rr_exp[j]});
            out_rdy = 1'b1;
            step();
        end
        chk("rr_empty", {31'b0, out_v}, 32'd0);

        // Full VC0 while the router pops it
        out_rdy = 1'b0;
        for (int j = 0; j < 4; j++) send_pkt(1'b0, 28'h00000F0 + D_W'(j));
        step();
        chk("fp_full", {30'b0, vc_full}, 32'h1);
        i_vc    = 1'b0;
        i_data  = 28'h00000F4;
        i_v     = 1'b1;
        out_rdy = 1'b1;
        step();
        chk("fp_no_ack", {31'b0, i_ack}, 32'd0);
        chk("fp_head1", {4'b0, out_data}, 32'h00000F1);
        step();
        chk("fp_ack", {31'b0, i_ack}, 32'd1);
        chk("fp_head2", {4'b0, out_data}, 32'h00000F2);
        i_v = 1'b0;
        step();
        chk("fp_head3", {4'b0, out_data}, 32'h00000F3);
        step();
        chk("fp_head4", {4'b0, out_data}, 32'h00000F4);
        step();
        chk("fp_empty", {31'b0, out_v}, 32'd0);
        chk("fp_in_cnt", pkt_in_cnt, 32'd21);
        chk("fp_out_cnt", pkt_out_cnt, 32'd21);

        // Asynchronous reset with traffic buffered and an ack in flight
        out_rdy = 1'b0;
        send_pkt(1'b0, 28'h0000C00);
        send_pkt(1'b1, 28'h0000C01);
        send_pkt(1'b1, 28'h0000C02);
        send_pkt(1'b1, 28'h0000C03);
        i_vc   = 1'b1;
        i_data = 28'h0000C04;
        i_v    = 1'b1;
        step();
        step();
        chk("ar_pre_ack", {31'b0, i_ack}, 32'd1);
        chk("ar_pre_full", {30'b0, vc_full}, 32'h2);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_ack", {31'b0, i_ack}, 32'd0);
        chk("ar_out_v", {31'b0, out_v}, 32'd0);
        chk("ar_vc_full", {30'b0, vc_full}, 32'd0);
        chk("ar_in_cnt", pkt_in_cnt, 32'd0);
        chk("ar_out_cnt", pkt_out_cnt, 32'd0);
        step();
        chk("ar_held_ack", {31'b0, i_ack}, 32'd0);
        chk("ar_held_out_v", {31'b0, out_v}, 32'd0);
        i_v = 1'b0;
        rst = 1'b1;
        step();
        b2b(28'h0200000, 32'd0, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
